// File: rtl/sdec_converter_if.sv
// Handshake bundle for the signed-binary to sign + BCD converter.
//   in_valid/in_ready/in_data         : upstream value, valid/ready handshake
//   out_valid/out_ready/out_neg/out_bcd : finished result, valid/ready handshake
// master : the environment side (drives inputs, consumes results)
// slave  : the converter side
interface sdec_converter_if #(
    parameter int unsigned W      = 17,
    parameter int unsigned DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_neg;
    logic [4*DIGITS-1:0]   out_bcd;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_neg, out_bcd
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_neg, out_bcd
    );
endinterface

// File: rtl/sdec_converter.sv
// Sequential signed-binary to sign + packed BCD converter (iterative double-dabble,
// one shift per clock, W clocks per conversion).
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : sdec_converter_if.slave
//            in_valid/in_ready/in_data  - value to convert, accepted only in IDLE
//            out_valid/out_ready        - result handshake, held in DONE
//            out_neg                    - 1 when the accepted value was negative
//            out_bcd                    - packed BCD magnitude, units digit in [3:0]
module sdec_converter #(
    parameter int unsigned W      = 17,
    parameter int unsigned DIGITS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    sdec_converter_if.slave  bus
);
    localparam int unsigned CntW = $clog2(W + 1);
    localparam int unsigned BcdW = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic              neg_q, neg_d;
    logic [W-1:0]      mag_q, mag_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_neg_q, out_neg_d;
    logic [BcdW-1:0]   out_bcd_q, out_bcd_d;

    logic [BcdW-1:0]   bcd_adj;
    logic [BcdW+W-1:0] work;
    logic [BcdW-1:0]   bcd_shift;
    logic [W-1:0]      mag_shift;

    // Add-3 correction, every digit judged on its pre-adjust value.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Magnitude MSB walks into BCD bit 0. The top BCD bit shifted out is always zero
    // because 10^DIGITS > 2^(W-1).
    always_comb begin
        work                   = {bcd_adj, mag_q};
        work                   = work << 1;
        {bcd_shift, mag_shift} = work;
    end

    always_comb begin
        state_d     = state_q;
        neg_d       = neg_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_neg_d   = out_neg_q;
        out_bcd_d   = out_bcd_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    neg_d   = bus.in_data[W-1];
                    // -2^(W-1) negates to itself, which reads correctly as unsigned.
                    mag_d   = bus.in_data[W-1] ? (~bus.in_data + W'(1)) : bus.in_data;
                    bcd_d   = '0;
                    cnt_d   = CntW'(W);
                    state_d = StShift;
                end
            end
            StShift: begin
                bcd_d = bcd_shift;
                mag_d = mag_shift;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    out_bcd_d   = bcd_shift;
                    out_neg_d   = neg_q;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            neg_q       <= 1'b0;
            mag_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_neg_q   <= 1'b0;
            out_bcd_q   <= '0;
        end else begin
            state_q     <= state_d;
            neg_q       <= neg_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_neg_q   <= out_neg_d;
            out_bcd_q   <= out_bcd_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.out_neg   = out_neg_q;
    assign bus.out_bcd   = out_bcd_q;
endmodule

// File: tb/tb_sdec_converter.sv
// Self-checking bench for sdec_converter: directed cases plus a random sweep,
// results checked through a scoreboard queue filled at each accept.
module tb_sdec_converter;
    localparam int unsigned W      = 17;
    localparam int unsigned DIGITS = 5;

    logic clk;
    logic rst_n;

    sdec_converter_if #(.W(W), .DIGITS(DIGITS)) bus ();

    sdec_converter #(.W(W), .DIGITS(DIGITS)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    int          n_out    = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random
    logic [31:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain decimal conversion of the signed value.
    function automatic logic [31:0] expect_of(input logic [W-1:0] v);
        int          s;
        int          m;
        logic [31:0] r;
        s = int'($signed(v));
        m = (s < 0) ? -s : s;
        r = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        r[4*DIGITS] = (s < 0);
        return r;
    endfunction

    // Output side: choose out_ready on the falling edge, then score any transfer
    // that the next rising edge will perform.
    initial begin
        logic [31:0] e;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", {11'b0, bus.out_neg, bus.out_bcd}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("result", {11'b0, bus.out_neg, bus.out_bcd}, e);
                end
                n_out++;
            end
        end
    end

    task automatic send(input logic [W-1:0] v);
        bit ok;
        ok = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            if (bus.in_ready) begin
                sb.push_back(expect_of(v));
                ok = 1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0 && !bus.out_valid) done = 1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_out_valid();
        bit seen;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (bus.out_valid) seen = 1;
            else @(negedge clk);
        end
        if (!seen) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int sweep_start;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #12;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_neg",   32'(bus.out_neg),   32'd0);
        check("rst_out_bcd",   32'(bus.out_bcd),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single value, latency and return to idle
        rdy_mode = 0;
        send(17'd26);
        wait_out_valid();
        check("latency", 32'(cyc - acc_cyc), 32'd17);
        check("done_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);
        drain();

        // 2: back-to-back values
        send(-17'sd51);
        send(17'd382);
        send(-17'sd1840);
        drain();

        // 3: extremes
        send(17'h10000);
        send(17'h0FFFF);
        send(17'h00000);
        send(17'h1FFFF);
        drain();

        // 4: backpressure
        @(posedge clk);
        rdy_mode = 1;
        send(17'd9999);
        wait_out_valid();
        bus.in_valid = 1'b1;
        bus.in_data  = 17'd123;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_bcd",   32'(bus.out_bcd),   32'h0000_9999);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        @(posedge clk);
        rdy_mode = 0;
        @(negedge clk);
        #2;
        check("pulse_in_ready", 32'(bus.in_ready), 32'd0);
        send(17'd123);
        drain();

        // 5: reset during conversion
        send(17'd382);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_bcd",   32'(bus.out_bcd),   32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(-17'sd7);
        drain();

        // 6: random sweep with throttled consumer
        @(posedge clk);
        rdy_mode    = 2;
        sweep_start = n_out;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) @(negedge clk);
            send(W'($urandom));
        end
        drain();
        check("sweep_count", 32'(n_out - sweep_start), 32'd2000);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
